// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS-subset CPU.
// Sequences fetch/decode/execute/memory/writeback over the shared datapath.
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction into IR, PC <= PC + 4
// DECODE    | decode IR, precompute branch target into ALUOut
// MEM_ADDR  | compute load/store effective address
// MEM_READ  | read data memory into MDR
// MEM_WB    | write MDR to Rt (LW retires)
// MEM_WRITE | write Rt to memory (SW retires)
// R_EXEC    | R-type ALU operation
// R_WB      | write ALUOut to Rd (R-type retires)
// I_EXEC    | immediate ALU operation
// I_WB      | write ALUOut to Rt (ADDI/XORI retire)
// BRANCH    | compare operands, conditionally load branch target
// JUMP      | load jump target
// JAL       | load jump target, link PC+4 into r31
// JR        | load PC from read1
// ILLEGAL   | unsupported encoding; sticky until reset
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_code,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_we,
    output logic       mem_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_UNUSED    = 4'd14,
        S_ILLEGAL   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;

    state_t state_q, state_d;
    // Remembers load vs store so MEM_ADDR need not look at the IR again.
    logic   is_sw_q, is_sw_d;

    logic fn_alu;
    logic fn_jr;

    always_comb begin
        fn_alu = (func == FN_ADD) || (func == FN_SUB) || (func == FN_SLT);
        fn_jr  = (func == FN_JR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        is_sw_d = is_sw_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d = (op_code == OP_SW);
                case (op_code)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_ADDI, OP_XORI: state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    OP_RTYPE: begin
                        if (fn_alu) begin
                            state_d = S_R_EXEC;
                        end else if (fn_jr) begin
                            state_d = S_JR;
                        end else begin
                            state_d = S_ILLEGAL;
                        end
                    end
                    default:          state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  state_d = is_sw_q ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            S_JR:        state_d = S_FETCH;
            S_ILLEGAL:   state_d = S_ILLEGAL;
            default:     state_d = S_ILLEGAL;
        endcase
    end

    always_comb begin
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_we    = 1'b0;
        mem_src   = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = 2'b00;
        wb_src    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = ALU_ADD;
        pc_src    = 2'b00;
        retire    = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                alu_src_b = 2'b01;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: mem_src = 1'b1;
            S_MEM_WB: begin
                reg_we = 1'b1;
                wb_src = 2'b01;
                retire = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_src = 1'b1;
                mem_we  = 1'b1;
                retire  = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                case (func)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                reg_we  = 1'b1;
                reg_dst = 2'b01;
                retire  = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (op_code == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            S_I_WB: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                retire    = 1'b1;
                pc_we     = (op_code == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = 2'b10;
                retire = 1'b1;
            end
            S_JAL: begin
                pc_we   = 1'b1;
                pc_src  = 2'b10;
                reg_we  = 1'b1;
                reg_dst = 2'b10;
                wb_src  = 2'b10;
                retire  = 1'b1;
            end
            S_JR: begin
                pc_we  = 1'b1;
                pc_src = 2'b11;
                retire = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
        // Reset suppresses every write and the retire strobe; selects stay live.
        if (reset) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            mem_we = 1'b0;
            reg_we = 1'b0;
            retire = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs queued
// with the stimulus that produces them, compared at the falling edge.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op_code;
    logic [5:0] func;
    logic       zero;
    logic       pc_we, ir_we, mem_we, mem_src, reg_we;
    logic [1:0] reg_dst, wb_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       retire, illegal;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .op_code   (op_code),
        .func      (func),
        .zero      (zero),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .mem_we    (mem_we),
        .mem_src   (mem_src),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wb_src    (wb_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .retire    (retire),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       illegal;
        logic       retire;
        logic       pc_we;
        logic       ir_we;
        logic       mem_we;
        logic       mem_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic       a;
        logic [1:0] b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } out_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        out_t       exp;
    } ent_t;

    localparam logic [5:0] R  = 6'b000000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] XORI = 6'b001110;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] JAL = 6'b000011;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    out_t obs;
    assign obs = {state, illegal, retire, pc_we, ir_we, mem_we, mem_src, reg_we,
                  reg_dst, wb_src, alu_src_a, alu_src_b, alu_op, pc_src};

    ent_t sb[$];
    ent_t e;
    int   checks = 0;
    int   errors = 0;
    int   retires;
    int   cyc;

    // Reference outputs for one cycle, written from the state table.
    function automatic out_t exp_out(input logic [3:0] st, input logic [5:0] op,
                                     input logic [5:0] fn, input logic z, input logic rst);
        out_t o;
        o = '0;
        o.st = st;
        case (st)
            4'd0:  begin o.ir_we = 1; o.pc_we = 1; o.b = 2'b01; end
            4'd1:  o.b = 2'b11;
            4'd2:  begin o.a = 1; o.b = 2'b10; end
            4'd3:  o.mem_src = 1;
            4'd4:  begin o.reg_we = 1; o.wb_src = 2'b01; o.retire = 1; end
            4'd5:  begin o.mem_src = 1; o.mem_we = 1; o.retire = 1; end
            4'd6:  begin
                o.a = 1;
                o.alu_op = (fn == F_SUB) ? 3'b001 : (fn == F_SLT) ? 3'b011 : 3'b000;
            end
            4'd7:  begin o.reg_we = 1; o.reg_dst = 2'b01; o.retire = 1; end
            4'd8:  begin o.a = 1; o.b = 2'b10; o.alu_op = (op == XORI) ? 3'b010 : 3'b000; end
            4'd9:  begin o.reg_we = 1; o.retire = 1; end
            4'd10: begin
                o.a = 1; o.alu_op = 3'b001; o.pc_src = 2'b01; o.retire = 1;
                o.pc_we = (op == BEQ) ? z : ~z;
            end
            4'd11: begin o.pc_we = 1; o.pc_src = 2'b10; o.retire = 1; end
            4'd12: begin
                o.pc_we = 1; o.pc_src = 2'b10; o.reg_we = 1;
                o.reg_dst = 2'b10; o.wb_src = 2'b10; o.retire = 1;
            end
            4'd13: begin o.pc_we = 1; o.pc_src = 2'b11; o.retire = 1; end
            4'd15: o.illegal = 1;
            default: ;
        endcase
        if (rst) begin
            o.pc_we = 0; o.ir_we = 0; o.mem_we = 0; o.reg_we = 0; o.retire = 0;
        end
        return o;
    endfunction

    task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic [3:0] st);
        ent_t n;
        n.rst = rst; n.op = op; n.fn = fn; n.z = z;
        n.exp = exp_out(st, op, fn, z, rst);
        sb.push_back(n);
    endtask

    // Expected state path of one whole instruction, starting at FETCH.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic [3:0] seq[$];
        seq = '{4'd0, 4'd1};
        case (op)
            LW:        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            SW:        seq = '{4'd0, 4'd1, 4'd2, 4'd5};
            ADDI, XORI: seq = '{4'd0, 4'd1, 4'd8, 4'd9};
            BEQ, BNE:  seq = '{4'd0, 4'd1, 4'd10};
            J:         seq = '{4'd0, 4'd1, 4'd11};
            JAL:       seq = '{4'd0, 4'd1, 4'd12};
            R: begin
                if (fn == F_ADD || fn == F_SUB || fn == F_SLT) seq = '{4'd0, 4'd1, 4'd6, 4'd7};
                else if (fn == F_JR) seq = '{4'd0, 4'd1, 4'd13};
                else seq = '{4'd0, 4'd1, 4'd15};
            end
            default:   seq = '{4'd0, 4'd1, 4'd15};
        endcase
        foreach (seq[i]) push(1'b0, op, fn, z, seq[i]);
    endtask

    task automatic test_reset();
        push(1, R, F_ADD, 0, 4'd0);
        push(1, R, F_ADD, 0, 4'd0);
        push(0, R, F_ADD, 0, 4'd0);
        push(0, R, F_ADD, 0, 4'd1);
        push(1, R, F_ADD, 0, 4'd6);
        push(1, R, F_ADD, 0, 4'd0);
        push_instr(R, F_ADD, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; op_code = e.op; func = e.fn; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL reset cyc %0d: got %h (state %0d) expected %h (state %0d)",
                         cyc, obs, obs.st, e.exp, e.exp.st);
            end
            cyc++;
        end
    endtask

    task automatic test_lw();
        push_instr(LW, 6'h15, 1);
        cyc = 0;
        retires = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; op_code = e.op; func = e.fn; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL lw cyc %0d: got %h (state %0d) expected %h (state %0d)",
                         cyc, obs, obs.st, e.exp, e.exp.st);
            end
            if (retire === 1'b1) retires++;
            cyc++;
        end
        checks++;
        if (retires !== 1) begin
            errors++;
            $display("FAIL lw_retire_count: got %0d expected 1", retires);
        end
    endtask

    task automatic test_back_to_back();
        push_instr(R, F_ADD, 0);
        push_instr(SW, 6'h00, 0);
        push_instr(JAL, 6'h3f, 1);
        cyc = 0;
        retires = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; op_code = e.op; func = e.fn; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL b2b cyc %0d: got %h (state %0d) expected %h (state %0d)",
                         cyc, obs, obs.st, e.exp, e.exp.st);
            end
            if (retire === 1'b1) retires++;
            cyc++;
        end
        checks++;
        if (retires !== 3 || cyc !== 11) begin
            errors++;
            $display("FAIL b2b_retire_count: got %0d retires in %0d cycles expected 3 in 11",
                     retires, cyc);
        end
    endtask

    task automatic test_alu_ops();
        push_instr(R, F_SUB, 0);
        push_instr(R, F_SLT, 1);
        push_instr(ADDI, 6'h2a, 0);
        push_instr(XORI, 6'h22, 1);
        push_instr(J, 6'h00, 0);
        push_instr(LW, 6'h00, 0);
        push_instr(SW, 6'h20, 1);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; op_code = e.op; func = e.fn; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL alu_ops cyc %0d: got %h (state %0d) expected %h (state %0d)",
                         cyc, obs, obs.st, e.exp, e.exp.st);
            end
            cyc++;
        end
    endtask

    task automatic test_branch();
        push_instr(BEQ, 6'h00, 1);
        push_instr(BEQ, 6'h00, 0);
        push_instr(BNE, 6'h00, 1);
        push_instr(BNE, 6'h00, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; op_code = e.op; func = e.fn; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL branch cyc %0d: got %h (state %0d) expected %h (state %0d)",
                         cyc, obs, obs.st, e.exp, e.exp.st);
            end
            cyc++;
        end
    endtask

    task automatic test_jr();
        push_instr(R, F_JR, 0);
        push_instr(R, F_JR, 1);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; op_code = e.op; func = e.fn; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL jr cyc %0d: got %h (state %0d) expected %h (state %0d)",
                         cyc, obs, obs.st, e.exp, e.exp.st);
            end
            cyc++;
        end
    endtask

    task automatic test_illegal();
        push_instr(6'b111111, 6'h20, 0);
        for (int i = 0; i < 10; i++) push(0, 6'b111111, 6'h20, i[0], 4'd15);
        push(1, 6'b111111, 6'h20, 0, 4'd15);
        push_instr(R, 6'b000111, 0);
        for (int i = 0; i < 11; i++) push(0, R, 6'b000111, i[0], 4'd15);
        push(1, R, 6'b000111, 0, 4'd15);
        push_instr(ADDI, 6'h00, 0);
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk); #1;
            reset = e.rst; op_code = e.op; func = e.fn; zero = e.z;
            @(negedge clk);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL illegal cyc %0d: got %h (state %0d) expected %h (state %0d)",
                         cyc, obs, obs.st, e.exp, e.exp.st);
            end
            cyc++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        op_code = R;
        func    = F_ADD;
        zero    = 1'b0;
        test_reset();
        test_lw();
        test_back_to_back();
        test_alu_ops();
        test_branch();
        test_jr();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
